// File: rtl/mips_pkg.sv
// mips_pkg: shared constants for the ID/EX ALU stage.
//   - ALU control codes understood by the EX-stage ALU
//   - MIPS opcode and funct values decoded by alu_decode
//   - instruction field slice positions
//   - ctrl_t: side-band control bits that travel with each instruction
package mips_pkg;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_XOR  = 4'd3;
  localparam logic [3:0] ALU_SLL  = 4'd4;
  localparam logic [3:0] ALU_SRL  = 4'd5;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_LUI  = 4'd10;
  localparam logic [3:0] ALU_NOR  = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int SH_MSB  = 10;
  localparam int SH_LSB  = 6;
  localparam int FN_MSB  = 5;
  localparam int FN_LSB  = 0;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  typedef struct packed {
    logic wr_en;
    logic mem_rd;
    logic mem_wr;
    logic ov_chk;
    logic illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/alu_decode.sv
// alu_decode: purely combinational instruction decode for the ID/EX stage.
// Ports:
//   instr   - MIPS instruction word
//   rs_val  - forwarded rs value
//   rt_val  - forwarded rt value
//   aluctl  - 4-bit ALU control code
//   a, b    - ALU operands
//   wr_reg  - destination register number
//   ctrl    - wr_en / mem_rd / mem_wr / ov_chk / illegal
module alu_decode
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [31:0]      instr,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic [3:0]       aluctl,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [4:0]       wr_reg,
  output ctrl_t            ctrl
);

  logic [5:0]       op;
  logic [5:0]       funct;
  logic [4:0]       rt_f;
  logic [4:0]       rd_f;
  logic [4:0]       shamt;
  logic [15:0]      imm;
  logic [WIDTH-1:0] sext_imm;
  logic [WIDTH-1:0] zext_imm;
  logic             legal;
  logic             wr_raw;
  logic             unused_rs_field;

  assign op       = instr[OP_MSB:OP_LSB];
  assign funct    = instr[FN_MSB:FN_LSB];
  assign rt_f     = instr[RT_MSB:RT_LSB];
  assign rd_f     = instr[RD_MSB:RD_LSB];
  assign shamt    = instr[SH_MSB:SH_LSB];
  assign imm      = instr[IMM_MSB:IMM_LSB];
  assign sext_imm = {{(WIDTH-16){imm[15]}}, imm};
  assign zext_imm = {{(WIDTH-16){1'b0}}, imm};

  // rs arrives already resolved through rs_val; the field itself is not needed.
  assign unused_rs_field = ^instr[RS_MSB:RS_LSB];

  always_comb begin
    aluctl      = ALU_AND;
    a           = rs_val;
    b           = rt_val;
    wr_reg      = rt_f;
    legal       = 1'b1;
    wr_raw      = 1'b0;
    ctrl        = CTRL_NONE;

    case (op)
      OP_RTYPE: begin
        wr_reg = rd_f;
        wr_raw = 1'b1;
        case (funct)
          F_ADD:  begin aluctl = ALU_ADD; ctrl.ov_chk = 1'b1; end
          F_ADDU: aluctl = ALU_ADD;
          F_SUB:  begin aluctl = ALU_SUB; ctrl.ov_chk = 1'b1; end
          F_SUBU: aluctl = ALU_SUB;
          F_AND:  aluctl = ALU_AND;
          F_OR:   aluctl = ALU_OR;
          F_XOR:  aluctl = ALU_XOR;
          F_NOR:  aluctl = ALU_NOR;
          F_SLT:  aluctl = ALU_SLT;
          F_SLTU: aluctl = ALU_SLTU;
          F_SLL:  begin aluctl = ALU_SLL; a = {{(WIDTH-5){1'b0}}, shamt}; end
          F_SRL:  begin aluctl = ALU_SRL; a = {{(WIDTH-5){1'b0}}, shamt}; end
          F_SRA:  begin aluctl = ALU_SRA; a = {{(WIDTH-5){1'b0}}, shamt}; end
          // The ALU shifts by the whole of A, so the amount must be masked here.
          F_SLLV: begin aluctl = ALU_SLL; a = {{(WIDTH-5){1'b0}}, rs_val[4:0]}; end
          F_SRLV: begin aluctl = ALU_SRL; a = {{(WIDTH-5){1'b0}}, rs_val[4:0]}; end
          F_SRAV: begin aluctl = ALU_SRA; a = {{(WIDTH-5){1'b0}}, rs_val[4:0]}; end
          default: legal = 1'b0;
        endcase
      end
      OP_ADDI:  begin aluctl = ALU_ADD;  b = sext_imm; wr_raw = 1'b1; ctrl.ov_chk = 1'b1; end
      OP_ADDIU: begin aluctl = ALU_ADD;  b = sext_imm; wr_raw = 1'b1; end
      OP_SLTI:  begin aluctl = ALU_SLT;  b = sext_imm; wr_raw = 1'b1; end
      OP_SLTIU: begin aluctl = ALU_SLTU; b = sext_imm; wr_raw = 1'b1; end
      OP_ANDI:  begin aluctl = ALU_AND;  b = zext_imm; wr_raw = 1'b1; end
      OP_ORI:   begin aluctl = ALU_OR;   b = zext_imm; wr_raw = 1'b1; end
      OP_XORI:  begin aluctl = ALU_XOR;  b = zext_imm; wr_raw = 1'b1; end
      OP_LUI:   begin aluctl = ALU_LUI;  b = zext_imm; wr_raw = 1'b1; end
      OP_LW:    begin aluctl = ALU_ADD;  b = sext_imm; wr_raw = 1'b1; ctrl.mem_rd = 1'b1; end
      OP_SW:    begin aluctl = ALU_ADD;  b = sext_imm; ctrl.mem_wr = 1'b1; end
      OP_BEQ, OP_BNE: aluctl = ALU_SUB;
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      aluctl = ALU_AND;
      wr_reg = 5'd0;
      wr_raw = 1'b0;
      ctrl   = CTRL_NONE;
    end
    ctrl.illegal = !legal;
    // $0 is hardwired; never let a write to it reach WB.
    ctrl.wr_en   = wr_raw && (wr_reg != 5'd0);
  end

endmodule

// File: rtl/id_ex_alu_stage.sv
// id_ex_alu_stage: ID/EX pipeline register feeding the EX-stage ALU.
// Decode is done by alu_decode; this module holds the register and the
// valid/ready handshake with stall and flush.
// Ports:
//   clk, rst (sync, active-high), flush
//   in_valid/in_ready, in_instr, in_rs_val, in_rt_val   - from ID
//   out_valid/out_ready                                 - to EX
//   out_aluctl, out_a, out_b                            - ALU inputs
//   out_store_data, out_wr_reg, out_wr_en,
//   out_mem_rd, out_mem_wr, out_ov_chk, out_illegal     - side-band
module id_ex_alu_stage
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [WIDTH-1:0] in_rs_val,
  input  logic [WIDTH-1:0] in_rt_val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_aluctl,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_store_data,
  output logic [4:0]       out_wr_reg,
  output logic             out_wr_en,
  output logic             out_mem_rd,
  output logic             out_mem_wr,
  output logic             out_ov_chk,
  output logic             out_illegal
);

  logic [3:0]       dec_aluctl;
  logic [WIDTH-1:0] dec_a;
  logic [WIDTH-1:0] dec_b;
  logic [4:0]       dec_wr_reg;
  ctrl_t            dec_ctrl;
  ctrl_t            ctrl_q;
  logic             load;

  alu_decode #(.WIDTH(WIDTH)) u_decode (
    .instr  (in_instr),
    .rs_val (in_rs_val),
    .rt_val (in_rt_val),
    .aluctl (dec_aluctl),
    .a      (dec_a),
    .b      (dec_b),
    .wr_reg (dec_wr_reg),
    .ctrl   (dec_ctrl)
  );

  assign in_ready = !out_valid || out_ready;
  // A flush drops whatever is offered in the same cycle.
  assign load     = in_valid && in_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst)            out_valid <= 1'b0;
    else if (flush)     out_valid <= 1'b0;
    else if (load)      out_valid <= 1'b1;
    else if (out_ready) out_valid <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_aluctl     <= '0;
      out_a          <= '0;
      out_b          <= '0;
      out_store_data <= '0;
      out_wr_reg     <= '0;
      ctrl_q         <= CTRL_NONE;
    end else if (load) begin
      out_aluctl     <= dec_aluctl;
      out_a          <= dec_a;
      out_b          <= dec_b;
      out_store_data <= in_rt_val;
      out_wr_reg     <= dec_wr_reg;
      ctrl_q         <= dec_ctrl;
    end
  end

  // Controls are gated so a flushed or consumed slot never looks live downstream.
  assign out_wr_en   = out_valid && ctrl_q.wr_en;
  assign out_mem_rd  = out_valid && ctrl_q.mem_rd;
  assign out_mem_wr  = out_valid && ctrl_q.mem_wr;
  assign out_ov_chk  = out_valid && ctrl_q.ov_chk;
  assign out_illegal = out_valid && ctrl_q.illegal;

endmodule

// File: doc/id_ex_alu_stage.md
Name: id_ex_alu_stage

Overview:
- ID/EX pipeline stage sitting directly upstream of the EX-stage ALU.
- Accepts a decoded-stage instruction word plus register-file operands, and decodes opcode/funct into the 4-bit ALU control code.
- Forms the A/B operands (shift amount, sign/zero-extended immediate) and registers everything behind a valid/ready handshake with stall and flush.
- Outputs drive the ALU's ALUctl/A/B inputs directly; MEM/WB side-band controls travel alongside.

Parameters:
- WIDTH, 32, datapath width of operands and outputs (only 32 supported).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  kill contents of the stage (branch/exception redirect).
- in_valid  input  1  upstream holds a valid instruction.
- in_ready  output  1  stage can accept this cycle.
- in_instr  input  32  MIPS instruction word.
- in_rs_val  input  WIDTH  forwarded rs value.
- in_rt_val  input  WIDTH  forwarded rt value.
- out_valid  output  1  registered instruction valid for EX.
- out_ready  input  1  EX consumes this cycle.
- out_aluctl  output  4  ALU control code.
- out_a  output  WIDTH  ALU operand A.
- out_b  output  WIDTH  ALU operand B.
- out_store_data  output  WIDTH  rt value for stores.
- out_wr_reg  output  5  destination register.
- out_wr_en  output  1  register write enable.
- out_mem_rd  output  1  load.
- out_mem_wr  output  1  store.
- out_ov_chk  output  1  signed-overflow trap check required (add, addi, sub).
- out_illegal  output  1  unrecognised opcode/funct.

Behaviour:
- ALU code set: AND=0, OR=1, ADD=2, XOR=3, SLL=4 (B<<A), SRL=5, SUB=6, SLTU=7, SLT=8, SRA=9, LUI=10, NOR=12. Code 11 and codes 13-15 are never emitted.
- R-type (op 0x00), A=rs, B=rt, wr_reg=rd:
  - funct 20/21 → 2
  - funct 22/23 → 6
  - funct 24 → 0
  - funct 25 → 1
  - funct 26 → 3
  - funct 27 → 12
  - funct 2A → 8
  - funct 2B → 7
- R-type fixed shifts: funct 00/02/03 → 4/5/9 with A = zero-extended shamt [10:6].
- R-type variable shifts: funct 04/06/07 → 4/5/9 with A = {27'b0, rs[4:0]} (ALU shifts by full A, so masking is mandatory).
- ov_chk=1 only for funct 20 and 22.
- I-type, A=rs, wr_reg=rt:
  - op 08/09 → 2, sext imm; ov_chk=1 only for op 08.
  - op 0A → 8, sext imm.
  - op 0B → 7, sext imm.
  - op 0C/0D/0E → 0/1/3, zext imm.
  - op 0F → 10, B={16'b0, imm}.
  - op 23 (lw) → 2, sext, mem_rd=1.
  - op 2B (sw) → 2, sext, mem_wr=1, wr_en=0, store_data=rt.
  - op 04/05 (beq/bne) → 6, B=rt, wr_en=0.
- Writes to $0 are suppressed: if wr_reg=0 then wr_en=0.
- Unrecognised opcode or funct: aluctl=0, wr_en=mem_rd=mem_wr=ov_chk=0, illegal=1. The entry still flows downstream with valid=1.
- Handshake: in_ready = !out_valid || out_ready (combinational). Load occurs when in_valid && in_ready; latency is 1 cycle. While out_valid && !out_ready, all outputs hold stable.
- out_valid next-state priority:
  1. rst → 0
  2. flush → 0
  3. load → 1
  4. out_ready → 0
  5. otherwise hold
- Flush in the same cycle as a would-be load: the input is dropped (not loaded), and in_ready is still reported per the formula.
- Reset: out_valid=0 and every registered output cleared to 0. Reset mid-stall discards the held entry. Data registers may update only on load; the control outputs (wr_en, mem_rd, mem_wr, ov_chk, illegal) are zero whenever out_valid=0.

Decomposition:
- Package mips_pkg holds:
  - ALU code localparams (ALU_AND…ALU_NOR)
  - opcode and funct constants
  - instruction field slice positions
- One combinational sub-module, alu_decode: instr, rs_val, rt_val → aluctl, a, b, wr_reg and control bits. The top holds only the pipeline register and handshake.

Test Plan:
- rst=1 for 2 cycles with in_valid=1 → out_valid=0, all outputs 0, in_ready=1.
- addi $5,$3,-4 (0x2065FFFC), rs=10, out_ready=1 → next cycle: aluctl=2, a=10, b=0xFFFFFFFC, wr_reg=5, wr_en=1, ov_chk=1.
- srav $2,$4,$6 (0x00C41007), rs=0x00000123, rt=0x80000000 → aluctl=9, a=3, b=0x80000000, wr_reg=2.
- Back-pressure: load ori (0x3421ABCD, rs=0), hold out_ready=0 for 3 cycles while new in_valid → outputs stable with b=0x0000ABCD and in_ready=0; raise out_ready → next instruction appears the following cycle, no loss or duplication.
- flush asserted with in_valid=1 and out_valid=1 → next cycle out_valid=0, input not captured; sw (0xAC220008) → mem_wr=1, wr_en=0, b=8.
- Illegal op 0x3F / R-funct 0x3F → illegal=1, aluctl=0, wr_en=0; sll $0,$0,0 (0x00000000) → aluctl=4, wr_en=0.
